// File: rtl/hack_mem_pkg.sv
// Shared widths, command opcodes and sequencer states for the Hack data RAM loader.
package hack_mem_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_SUM   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SUM,
    S_DONE
  } state_e;

endpackage

// File: rtl/ram16k_loader.sv
// Takes the RAM port from the CPU to fill, stream-load or checksum an address range.
// CLEAR/SUM finish len+1 cycles after accept, LOAD follows in_valid; cmd_ready only in IDLE.
module ram16k_loader
  import hack_mem_pkg::*;
(
  input  logic              clock_i,
  input  logic              aclr_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [ADDR_W:0]   cmd_len_i,
  input  logic [DATA_W-1:0] fill_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] sum_o,
  input  logic [ADDR_W-1:0] cpu_address_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_wren_i,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wren_o,
  input  logic [DATA_W-1:0] ram_q_i
);

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q,  base_d;
  logic [ADDR_W:0]     len_q,   len_d;
  logic [ADDR_W:0]     idx_q,   idx_d;
  logic [DATA_W-1:0]   fill_q,  fill_d;
  logic [DATA_W-1:0]   sum_q,   sum_d;
  logic                err_q,   err_d;
  logic                last_w;
  logic [ADDR_W-1:0]   loader_addr;

  // Truncating to ADDR_W bits gives the modulo-DEPTH wrap for free.
  assign loader_addr = base_q + idx_q[ADDR_W-1:0];
  assign last_w      = (idx_q == len_q - LEN_ONE);

  assign busy_o = (state_q != S_IDLE);
  assign err_o  = err_q;
  assign sum_o  = sum_q;

  always_ff @(posedge clock_i) begin
    if (aclr_i) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      fill_q  <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    idx_d         = idx_q;
    fill_d        = fill_q;
    sum_d         = sum_q;
    err_d         = err_q;
    cmd_ready_o   = 1'b0;
    in_ready_o    = 1'b0;
    done_o        = 1'b0;
    ram_address_o = cpu_address_i;
    ram_data_o    = cpu_data_i;
    ram_wren_o    = cpu_wren_i;

    // Once busy the loader owns the port; CPU writes are silently dropped.
    if (state_q != S_IDLE) begin
      ram_address_o = loader_addr;
      ram_data_o    = fill_q;
      ram_wren_o    = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          base_d = cmd_base_i;
          len_d  = cmd_len_i;
          fill_d = fill_i;
          idx_d  = '0;
          sum_d  = '0;
          err_d  = 1'b0;
          if (op_e'(cmd_op_i) == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (cmd_len_i == '0) begin
            state_d = S_DONE;
          end else begin
            case (op_e'(cmd_op_i))
              OP_CLEAR: state_d = S_CLEAR;
              OP_LOAD:  state_d = S_LOAD;
              default:  state_d = S_SUM;
            endcase
          end
        end
      end
      S_CLEAR: begin
        ram_wren_o = 1'b1;
        idx_d      = idx_q + LEN_ONE;
        if (last_w) state_d = S_DONE;
      end
      S_LOAD: begin
        in_ready_o = 1'b1;
        ram_data_o = in_data_i;
        if (in_valid_i) begin
          ram_wren_o = 1'b1;
          idx_d      = idx_q + LEN_ONE;
          if (last_w) state_d = S_DONE;
        end
      end
      S_SUM: begin
        sum_d = sum_q + ram_q_i;
        idx_d = idx_q + LEN_ONE;
        if (last_w) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram16k_loader.sv
// Bench for ram16k_loader: behavioural RAM plus an array-based reference memory and checksum model.
module tb_ram16k_loader;
  import hack_mem_pkg::*;

  logic              clock, aclr;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W:0]   cmd_len;
  logic [DATA_W-1:0] fill;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic              busy, done, err;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_wren;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] ld_q[$];
  int n_cmp, n_bad;

  ram16k_loader dut (
    .clock_i(clock), .aclr_i(aclr),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_base_i(cmd_base), .cmd_len_i(cmd_len), .fill_i(fill),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .busy_o(busy), .done_o(done), .err_o(err), .sum_o(sum),
    .cpu_address_i(cpu_address), .cpu_data_i(cpu_data), .cpu_wren_i(cpu_wren),
    .ram_address_o(ram_address), .ram_data_o(ram_data), .ram_wren_o(ram_wren),
    .ram_q_i(ram_q)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // The RAM itself: synchronous write, combinational read.
  always_ff @(posedge clock) if (ram_wren) mem[ram_address] <= ram_data;
  assign ram_q = mem[ram_address];

  function automatic int mem_diffs();
    int n = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== ref_mem[a]) n++;
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] model_sum(input int base, input int len);
    int acc = 0;
    for (int k = 0; k < len; k++) acc = (acc + int'(ref_mem[(base + k) % DEPTH])) % 65536;
    return DATA_W'(acc);
  endfunction

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clock); #1;
    cpu_address = a; cpu_data = d; cpu_wren = 1'b1;
    @(posedge clock); #1;
    cpu_wren = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issues one command and watches it to completion. Cycle c is the c-th cycle after the accept edge.
  task automatic run_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                         input logic [DATA_W-1:0] fl, input bit vrand, input logic [31:0] vpat,
                         output int done_cyc, output int last_xfer, output logic err_s,
                         output logic [DATA_W-1:0] sum_s, output int wren_cnt, output int stall_wr,
                         output int rdy_busy, output logic rdy_after);
    int  xf;
    logic v;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len; fill = fl;
    done_cyc = -1; last_xfer = -1; xf = 0; wren_cnt = 0; stall_wr = 0; rdy_busy = 0;
    err_s = 1'bx; sum_s = 'x;
    for (int c = 1; c <= 20000 && done_cyc < 0; c++) begin
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      cpu_wren = 1'b1; cpu_address = ADDR_W'($urandom); cpu_data = DATA_W'($urandom);
      if (op == 2'd1 && xf < int'(len)) begin
        v = vrand ? 1'($urandom_range(0, 1)) : (c <= 32 ? vpat[c-1] : 1'b1);
        in_valid = v;
        in_data  = v ? ld_q[xf] : DATA_W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      if (ram_wren === 1'b1) wren_cnt++;
      if (op == 2'd1 && in_valid === 1'b0 && ram_wren === 1'b1) stall_wr++;
      if (cmd_ready !== 1'b0) rdy_busy++;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin xf++; last_xfer = c; end
      if (done === 1'b1) begin done_cyc = c; err_s = err; sum_s = sum; end
    end
    @(posedge clock); #1;
    cpu_wren = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    rdy_after = (cmd_ready === 1'b1) && (busy === 1'b0) && (done === 1'b0);
  endtask

  task automatic test_reset();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    aclr = 1'b1;
    repeat (3) @(posedge clock);
    #1 aclr = 1'b0;
    @(negedge clock);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (sum !== 16'h0000) begin n_bad++; $display("FAIL reset_sum: got %h want 0000", sum); end
    a = ADDR_W'($urandom); d = DATA_W'($urandom);
    @(posedge clock); #1;
    cpu_address = a; cpu_data = d; cpu_wren = 1'b1;
    @(negedge clock);
    n_cmp++; if (ram_address !== a || ram_data !== d || ram_wren !== 1'b1) begin
      n_bad++; $display("FAIL idle_passthru: got %h/%h/%b want %h/%h/1", ram_address, ram_data, ram_wren, a, d);
    end
    @(posedge clock); #1;
    cpu_wren = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic test_clear_full();
    int dc, lx, wc, sw, rb, nd;
    logic e, ra;
    logic [DATA_W-1:0] s;
    for (int a = 0; a < DEPTH; a++) begin
      @(posedge clock); #1;
      cpu_address = ADDR_W'(a); cpu_data = DATA_W'($urandom); cpu_wren = 1'b1;
      ref_mem[a] = cpu_data;
    end
    @(posedge clock); #1;
    cpu_wren = 1'b0;
    nd = mem_diffs();
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL preload_mem: got %0d bad words want 0", nd); end
    run_cmd(2'd0, '0, 15'd16384, 16'h0000, 1'b0, '0, dc, lx, e, s, wc, sw, rb, ra);
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 16'h0000;
    n_cmp++; if (dc !== 16385) begin n_bad++; $display("FAIL clear_full_done_cycle: got %0d want 16385", dc); end
    n_cmp++; if (wc !== 16384) begin n_bad++; $display("FAIL clear_full_writes: got %0d want 16384", wc); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL clear_full_err: got %b want 0", e); end
    n_cmp++; if (rb !== 0) begin n_bad++; $display("FAIL clear_full_ready_busy: got %0d want 0", rb); end
    n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL clear_full_ready_after: got %b want 1", ra); end
    nd = mem_diffs();
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL clear_full_mem: got %0d bad words want 0", nd); end
  endtask

  task automatic test_load_stalls();
    int dc, lx, wc, sw, rb, nd;
    logic e, ra;
    logic [DATA_W-1:0] s;
    ld_q.delete();
    for (int k = 1; k <= 4; k++) ld_q.push_back(DATA_W'(k));
    run_cmd(2'd1, 14'd100, 15'd4, 16'h0000, 1'b0, 32'b101101, dc, lx, e, s, wc, sw, rb, ra);
    for (int k = 0; k < 4; k++) ref_mem[100 + k] = DATA_W'(k + 1);
    n_cmp++; if (lx !== 6) begin n_bad++; $display("FAIL load_last_xfer: got %0d want 6", lx); end
    n_cmp++; if (dc !== 7) begin n_bad++; $display("FAIL load_done_cycle: got %0d want 7", dc); end
    n_cmp++; if (sw !== 0) begin n_bad++; $display("FAIL load_stall_writes: got %0d want 0", sw); end
    n_cmp++; if (wc !== 4) begin n_bad++; $display("FAIL load_writes: got %0d want 4", wc); end
    nd = mem_diffs();
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL load_mem: got %0d bad words want 0", nd); end
  endtask

  task automatic test_sum_overflow();
    int dc, lx, wc, sw, rb;
    logic e, ra;
    logic [DATA_W-1:0] s;
    cpu_write(14'd16383, 16'hFFFF);
    cpu_write(14'd0, 16'h0003);
    run_cmd(2'd2, 14'd16383, 15'd2, 16'h0000, 1'b0, '0, dc, lx, e, s, wc, sw, rb, ra);
    n_cmp++; if (s !== 16'h0002) begin n_bad++; $display("FAIL sum_wrap: got %h want 0002", s); end
    n_cmp++; if (dc !== 3) begin n_bad++; $display("FAIL sum_done_cycle: got %0d want 3", dc); end
    n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL sum_writes: got %0d want 0", wc); end
    n_cmp++; if (sum !== 16'h0002) begin n_bad++; $display("FAIL sum_held: got %h want 0002", sum); end
  endtask

  task automatic test_zero_len_rsvd();
    int dc, lx, wc, sw, rb, nd;
    logic e, ra;
    logic [DATA_W-1:0] s;
    run_cmd(2'd0, ADDR_W'($urandom), 15'd0, DATA_W'($urandom), 1'b0, '0, dc, lx, e, s, wc, sw, rb, ra);
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL zlen_done_cycle: got %0d want 1", dc); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL zlen_err: got %b want 0", e); end
    n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL zlen_writes: got %0d want 0", wc); end
    n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL zlen_ready_after: got %b want 1", ra); end
    run_cmd(2'd3, ADDR_W'($urandom), 15'd5, DATA_W'($urandom), 1'b0, '0, dc, lx, e, s, wc, sw, rb, ra);
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL rsvd_done_cycle: got %0d want 1", dc); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL rsvd_err: got %b want 1", e); end
    n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL rsvd_writes: got %0d want 0", wc); end
    nd = mem_diffs();
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL zlen_rsvd_mem: got %0d bad words want 0", nd); end
  endtask

  task automatic test_busy_lockout();
    int rdy_cyc, clr_done, sum_done, nd;
    logic [DATA_W-1:0] s, esum;
    rdy_cyc = -1; clr_done = -1; sum_done = -1; s = 'x;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_base = 14'd0; cmd_len = 15'd10; fill = 16'hAAAA;
    for (int k = 0; k < 10; k++) ref_mem[k] = 16'hAAAA;
    esum = model_sum(0, 10);
    for (int c = 1; c <= 200 && sum_done < 0; c++) begin
      @(posedge clock); #1;
      if (c == 1) begin cmd_op = 2'd2; cmd_base = 14'd0; cmd_len = 15'd10; end
      if (c == 13) cmd_valid = 1'b0;
      cpu_wren = (c <= 10); cpu_address = 14'd5; cpu_data = 16'h1234;
      @(negedge clock);
      if (cmd_ready === 1'b1 && rdy_cyc < 0) rdy_cyc = c;
      if (done === 1'b1) begin
        if (clr_done < 0) clr_done = c;
        else begin sum_done = c; s = sum; end
      end
    end
    cmd_valid = 1'b0; cpu_wren = 1'b0;
    n_cmp++; if (clr_done !== 11) begin n_bad++; $display("FAIL lock_clear_done: got %0d want 11", clr_done); end
    n_cmp++; if (rdy_cyc !== 12) begin n_bad++; $display("FAIL lock_ready_cycle: got %0d want 12", rdy_cyc); end
    n_cmp++; if (sum_done !== 23) begin n_bad++; $display("FAIL lock_second_done: got %0d want 23", sum_done); end
    n_cmp++; if (s !== esum) begin n_bad++; $display("FAIL lock_second_sum: got %h want %h", s, esum); end
    n_cmp++; if (mem[5] !== 16'hAAAA) begin n_bad++; $display("FAIL lock_cpu_dropped: got %h want aaaa", mem[5]); end
    nd = mem_diffs();
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL lock_mem: got %0d bad words want 0", nd); end
  endtask

  task automatic test_random();
    int dc, lx, wc, sw, rb, nd, len, edc, ewc;
    logic e, ra;
    logic [1:0] op;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] s, fl, esum;
    for (int it = 0; it < 10; it++) begin
      op   = 2'($urandom_range(0, 2));
      base = $urandom_range(0, 1) ? ADDR_W'(DEPTH - 1 - $urandom_range(0, 20)) : ADDR_W'($urandom);
      len  = $urandom_range(1, 40);
      fl   = DATA_W'($urandom);
      ld_q.delete();
      for (int k = 0; k < len; k++) ld_q.push_back(DATA_W'($urandom));
      esum = model_sum(int'(base), len);
      run_cmd(op, base, (ADDR_W+1)'(len), fl, 1'b1, '0, dc, lx, e, s, wc, sw, rb, ra);
      for (int k = 0; k < len; k++) begin
        if (op == 2'd0) ref_mem[(int'(base) + k) % DEPTH] = fl;
        if (op == 2'd1) ref_mem[(int'(base) + k) % DEPTH] = ld_q[k];
      end
      edc = (op == 2'd1) ? ((lx > 0) ? lx + 1 : -2) : len + 1;
      ewc = (op == 2'd2) ? 0 : len;
      n_cmp++; if (dc !== edc) begin n_bad++; $display("FAIL rnd%0d_op%0d_done_cycle: got %0d want %0d", it, op, dc, edc); end
      n_cmp++; if (wc !== ewc) begin n_bad++; $display("FAIL rnd%0d_op%0d_writes: got %0d want %0d", it, op, wc, ewc); end
      n_cmp++; if (sw !== 0 || rb !== 0 || ra !== 1'b1 || e !== 1'b0) begin
        n_bad++; $display("FAIL rnd%0d_handshake: got stall_wr=%0d rdy_busy=%0d rdy_after=%b err=%b want 0/0/1/0", it, sw, rb, ra, e);
      end
      if (op == 2'd2) begin
        n_cmp++; if (s !== esum) begin n_bad++; $display("FAIL rnd%0d_sum: got %h want %h", it, s, esum); end
      end
      nd = mem_diffs();
      n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL rnd%0d_op%0d_mem: got %0d bad words want 0", it, op, nd); end
    end
  endtask

  task automatic test_reset_mid_load();
    int nd, dones;
    logic [ADDR_W-1:0] base, a;
    logic [DATA_W-1:0] w0, w1, d;
    base = 14'd16383; w0 = DATA_W'($urandom); w1 = DATA_W'($urandom); dones = 0;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_base = base; cmd_len = 15'd8;
    @(posedge clock); #1;
    cmd_valid = 1'b0; in_valid = 1'b1; in_data = w0;
    @(posedge clock); #1;
    in_data = w1;
    @(posedge clock); #1;
    in_valid = 1'b0; aclr = 1'b1;
    @(negedge clock);
    if (done === 1'b1) dones++;
    a = ADDR_W'($urandom_range(100, 200)); d = DATA_W'($urandom);
    @(posedge clock); #1;
    aclr = 1'b0; cpu_address = a; cpu_data = d; cpu_wren = 1'b1;
    @(negedge clock);
    if (done === 1'b1) dones++;
    n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: got busy=%b cmd_ready=%b in_ready=%b want 0/1/0", busy, cmd_ready, in_ready);
    end
    n_cmp++; if (ram_address !== a || ram_data !== d || ram_wren !== 1'b1) begin
      n_bad++; $display("FAIL abort_passthru: got %h/%h/%b want %h/%h/1", ram_address, ram_data, ram_wren, a, d);
    end
    @(posedge clock); #1;
    cpu_wren = 1'b0;
    repeat (3) begin @(negedge clock); if (done === 1'b1) dones++; end
    ref_mem[base] = w0; ref_mem[0] = w1; ref_mem[a] = d;
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
    nd = mem_diffs();
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL abort_mem: got %0d bad words want 0", nd); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    aclr = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_base = '0; cmd_len = '0; fill = '0;
    in_valid = 1'b0; in_data = '0; cpu_address = '0; cpu_data = '0; cpu_wren = 1'b0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 'x;
    test_reset();
    test_clear_full();
    test_load_stalls();
    test_sum_overflow();
    test_zero_len_rsvd();
    test_busy_lockout();
    test_random();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
